out_byte_uart: RTL and testbench
================================

# out_byte_uart

Serial console back-end for the SoC. Captures the CPU's memory-mapped output byte stream (`out_byte` / `out_byte_en`), buffers it in a small FIFO and transmits each byte as an 8N1 UART frame on `uart_tx`. It sits directly downstream of the `system` top, which produces one output byte per `out_byte_en` strobe.

## Interface
- `CLK_DIV`, default 434: clock cycles per UART bit (434 gives 115200 baud at 50 MHz); legal range 2..65535.
- `FIFO_DEPTH`, default 16: byte FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `out_byte` in 8: byte to transmit; sampled when `out_byte_en` is 1.
- `out_byte_en` in 1: write strobe; one byte per cycle high.
- `uart_tx` out 1: serial line, registered, idle high.
- `busy` out 1: 1 while the FIFO is non-empty or a frame is in progress.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full.

## Operation
- FIFO: circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter.
- Write: on an edge with `out_byte_en`=1 and level<FIFO_DEPTH, store `out_byte`.
- Full check: fullness is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs in that cycle, and `overflow` goes to 1.
- Simultaneous push and pop when not full: both take effect and level is unchanged.
- Transmitter FSM states:
  - IDLE: `uart_tx`=1. If FIFO is non-empty, pop the head into the shift register, clear the bit counter and the baud counter, and go to START.
  - START: `uart_tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLK_DIV cycles, then go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps to 0. A bit boundary occurs at the wrap.
- `busy` = (state≠IDLE) or (level≠0). It is registered-equivalent and has no glitches from combinational pop.
- `overflow` clears only on `reset`.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `fifo_level`=0, `overflow`=0, FSM in IDLE, pointers and counters at 0.
- Reset asserted mid-frame:
  - The frame is truncated, the FIFO is flushed, and `uart_tx`=1 from the first edge with `reset` high.
  - No partial frame resumes after reset.
- Write-to-line latency with the block idle and empty:
  - Byte sampled at edge E0; `fifo_level`=1 after E0.
  - Pop occurs at E1 and `uart_tx` falls after E1.
  - `fifo_level` returns to 0 after E1.
- Frame length: exactly 10×CLK_DIV cycles, measured from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames: STOP goes to IDLE, and IDLE pops in its single cycle. Consecutive frames are therefore separated by exactly 1 idle-high cycle, giving a period of 10×CLK_DIV+1.
- `fifo_level` and `overflow` update on the same edge as the push or pop that changes them.

## Test plan
- Single byte, CLK_DIV=4: pulse `out_byte_en` with `out_byte`=0x41.
  - `uart_tx` falls one edge later, then holds the levels 0,1,0,0,0,0,0,1,0,1, each for 4 cycles (40 cycles total).
  - `busy` falls the cycle after the stop bit ends.
- Burst, CLK_DIV=4, depth 16: write 0x55, 0xAA, 0x00 on consecutive cycles.
  - Three frames are decoded in order by the bench UART model, with start-to-start spacing of 41 cycles.
  - `fifo_level` peaks at 2.
  - `overflow` stays 0.
- Overflow, CLK_DIV=4, depth 4: write bytes 0..5 on six consecutive cycles.
  - Byte 0 is popped at E1; `fifo_level` reaches 4 after E4.
  - Byte 5 is dropped and `overflow`=1 after E5.
  - Decoded output is 0,1,2,3,4 only.
- Wrap-around, CLK_DIV=2, depth 4: write 20 incrementing bytes, each issued only when `fifo_level`<4.
  - All 20 bytes are decoded in order.
  - `overflow` stays 0.
  - The pointers wrap 5 times.
- Reset mid-frame, CLK_DIV=4: start 0xFF 0x00, and assert `reset` for 1 cycle during data bit 3 of the first frame.
  - `uart_tx`=1, `fifo_level`=0, `busy`=0 after the reset edge.
  - No further frames are sent.
  - A subsequent write of 0x41 transmits normally.
- Simultaneous events, depth 4, FIFO full, pop in progress: assert `out_byte_en` on the exact pop edge.
  - The byte is dropped and `overflow`=1.
  - `fifo_level` goes from 4 to 3.

Source files
------------

// File: rtl/out_byte_uart.sv
// out_byte_uart: serial console back-end. Buffers CPU output bytes in a small
// FIFO and sends each one as an 8N1 UART frame, LSB first.
//   clk, reset    : single clock, synchronous active-high reset
//   out_byte/_en  : byte write strobe, one byte per cycle high
//   uart_tx       : registered serial line, idle high
//   busy          : FIFO non-empty or frame in progress (registered)
//   fifo_level    : FIFO occupancy, 0..FIFO_DEPTH
//   overflow      : sticky flag, set when a write is dropped on a full FIFO
module out_byte_uart #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  out_byte,
    input  logic                        out_byte_en,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
    logic [LVL_W-1:0]  level_n;
    logic              tx_n, busy_n, overflow_n;
    logic              push, pop, baud_wrap;
    logic [7:0]        mem [FIFO_DEPTH];

    // Next-state, FIFO pointer and registered-output computation
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;
        overflow_n = overflow;
        pop        = 1'b0;
        tx_n       = 1'b1;
        baud_wrap  = (baud_cnt == BAUD_W'(CLK_DIV - 1));
        // Fullness is judged on the current level, before any same-cycle pop
        push       = out_byte_en && (fifo_level != LVL_W'(FIFO_DEPTH));

        if (out_byte_en && !push) begin
            overflow_n = 1'b1;
        end

        if (state != IDLE) begin
            baud_cnt_n = baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr];
                    rd_ptr_n   = rd_ptr + PTR_W'(1);
                    bit_cnt_n  = '0;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_n   = {1'b0, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (push) begin
            wr_ptr_n = wr_ptr + PTR_W'(1);
        end

        level_n = fifo_level + LVL_W'(push) - LVL_W'(pop);

        // Line level follows the state being entered so uart_tx stays registered
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE) || (level_n != '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            fifo_level <= level_n;
            uart_tx    <= tx_n;
            busy       <= busy_n;
            overflow   <= overflow_n;
        end
    end

    // FIFO storage; contents need no reset since pointers and level do
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= out_byte;
        end
    end

endmodule

// File: tb/tb_out_byte_uart.sv
// tb_out_byte_uart: directed + randomized bench for out_byte_uart.
// A transaction-level model predicts FIFO occupancy, busy, overflow and the
// line waveform from frame timing arithmetic; a bench UART receiver decodes
// uart_tx independently for byte-order and spacing checks.
module tb_out_byte_uart;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] out_byte = 8'h00;
    logic       out_byte_en = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    out_byte_uart #(
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .out_byte    (out_byte),
        .out_byte_en (out_byte_en),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] m_popped[$];
    int         next_pop = 0;
    int         cur_pop = 0;
    logic [7:0] cur_b = 8'h00;
    bit         have_frame = 1'b0;
    logic       m_ovf = 1'b0;

    // Bench UART receiver state
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic       prev_tx = 1'b1;

    int         peak = 0;
    logic [7:0] exp_burst [3] = '{8'h55, 8'hAA, 8'h00};
    logic [7:0] exp_sim   [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level from frame position: start, 8 data bits LSB first, stop
    function automatic logic exp_tx();
        int idx;
        if (!have_frame || cyc < cur_pop || cyc >= cur_pop + FRAME) return 1'b1;
        idx = (cyc - cur_pop) / D;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur_b[idx-1];
        return 1'b1;
    endfunction

    // Model of one clock edge: pops happen once the line is free, one frame
    // period (FRAME+1) apart; writes are judged full before the pop
    task automatic model_edge(input logic r, input logic en, input logic [7:0] b);
        bit full;
        cyc++;
        if (r) begin
            if (have_frame && cyc < cur_pop + FRAME && m_popped.size() != 0)
                void'(m_popped.pop_back());
            mq.delete();
            m_ovf      = 1'b0;
            have_frame = 1'b0;
            next_pop   = cyc + 1;
            return;
        end
        full = (mq.size() == DEPTH);
        if (cyc >= next_pop && mq.size() != 0) begin
            cur_b      = mq.pop_front();
            m_popped.push_back(cur_b);
            cur_pop    = cyc;
            have_frame = 1'b1;
            next_pop   = cyc + FRAME + 1;
        end
        if (en) begin
            if (!full) mq.push_back(b);
            else       m_ovf = 1'b1;
        end
    endtask

    // Mid-bit sampling receiver driven from the per-cycle line samples
    task automatic rx_update(input logic r);
        int i;
        if (r) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && prev_tx === 1'b1 && uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_start.push_back(cyc);
            end
            if (rx_active) begin
                if (rx_cnt % D == D / 2) begin
                    i = rx_cnt / D;
                    if (i >= 1 && i <= 8) rx_byte[i-1] = uart_tx;
                    if (i == 9) begin
                        check("rx_stop_bit", 32'(uart_tx), 32'd1);
                        rx_q.push_back(rx_byte);
                        rx_active = 1'b0;
                    end
                end
                rx_cnt++;
            end
        end
        prev_tx = uart_tx;
    endtask

    task automatic tick(input logic r, input logic en, input logic [7:0] b);
        reset       = r;
        out_byte_en = en;
        out_byte    = b;
        @(posedge clk);
        model_edge(r, en, b);
        #1;
        check("uart_tx",    32'(uart_tx),    32'(exp_tx()));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check("busy",       32'(busy),       32'(mq.size() != 0 || (have_frame && cyc < cur_pop + FRAME)));
        check("overflow",   32'(overflow),   32'(m_ovf));
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        rx_update(r);
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        check({tag, "_drained"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int sent;
        int guard;
        int p;

        // Reset state
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        check("rst_tx",    32'(uart_tx),    32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);

        // Single byte 0x41: latency, frame length, busy release
        base = rx_q.size();
        tick(1'b0, 1'b1, 8'h41);
        check("t1_level_e0", 32'(fifo_level), 32'd1);
        tick(1'b0, 1'b0, 8'h00);
        check("t1_tx_fall_e1", 32'(uart_tx), 32'd0);
        check("t1_level_e1",   32'(fifo_level), 32'd0);
        drain("t1", 200);
        check("t1_frame_len", 32'(cyc - rx_start[$]), 32'(FRAME));
        check("t1_count", 32'(rx_q.size() - base), 32'd1);
        check("t1_byte",  32'(rx_q[$]), 32'h41);

        // Burst of three back-to-back writes
        base = rx_q.size();
        peak = 0;
        tick(1'b0, 1'b1, 8'h55);
        tick(1'b0, 1'b1, 8'hAA);
        tick(1'b0, 1'b1, 8'h00);
        drain("t2", 400);
        check("t2_peak",  32'(peak), 32'd2);
        check("t2_count", 32'(rx_q.size() - base), 32'd3);
        for (int k = 0; k < 3; k++) check("t2_byte", 32'(rx_q[base + k]), 32'(exp_burst[k]));
        check("t2_gap1", 32'(rx_start[$-1] - rx_start[$-2]), 32'(FRAME + 1));
        check("t2_gap2", 32'(rx_start[$] - rx_start[$-1]), 32'(FRAME + 1));
        check("t2_ovf",  32'(overflow), 32'd0);

        // Overflow: six writes into a depth-4 FIFO
        base = rx_q.size();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b1, 8'(k));
            if (k == 4) check("t3_level_e4", 32'(fifo_level), 32'd4);
        end
        check("t3_ovf_e5",   32'(overflow), 32'd1);
        check("t3_level_e5", 32'(fifo_level), 32'd4);
        drain("t3", 600);
        check("t3_count", 32'(rx_q.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) check("t3_byte", 32'(rx_q[base + k]), 32'(k));

        // Wrap-around: 20 bytes with random gaps, writing only when not full
        tick(1'b1, 1'b0, 8'h00);
        base  = rx_q.size();
        sent  = 0;
        guard = 0;
        while (sent < 20 && guard < 5000) begin
            if (fifo_level < 3'd4 && $urandom_range(0, 1) == 1) begin
                tick(1'b0, 1'b1, 8'(8'h10 + 8'(sent)));
                sent++;
            end else begin
                tick(1'b0, 1'b0, 8'h00);
            end
            guard++;
        end
        check("t4_sent", 32'(sent), 32'd20);
        drain("t4", 600);
        check("t4_count", 32'(rx_q.size() - base), 32'd20);
        for (int k = 0; k < 20; k++) check("t4_byte", 32'(rx_q[base + k]), 32'(8'h10 + k));
        check("t4_ovf", 32'(overflow), 32'd0);

        // Randomized traffic, overflow allowed
        for (int k = 0; k < 300; k++) begin
            tick(1'b0, ($urandom_range(0, 7) == 0), 8'($urandom));
        end
        drain("t5", 1000);

        // Reset during data bit 3 of the first frame
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'hFF);
        tick(1'b0, 1'b1, 8'h00);
        p = cyc;
        guard = 0;
        while (cyc < p + 4 * D + 1 && guard < 100) begin
            tick(1'b0, 1'b0, 8'h00);
            guard++;
        end
        tick(1'b1, 1'b0, 8'h00);
        check("t6_tx",    32'(uart_tx),    32'd1);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_busy",  32'(busy),       32'd0);
        base = rx_q.size();
        for (int k = 0; k < 100; k++) tick(1'b0, 1'b0, 8'h00);
        check("t6_no_frames", 32'(rx_q.size() - base), 32'd0);
        tick(1'b0, 1'b1, 8'h41);
        drain("t6", 200);
        check("t6_count", 32'(rx_q.size() - base), 32'd1);
        check("t6_byte",  32'(rx_q[$]), 32'h41);

        // Write on the exact pop edge while full
        tick(1'b1, 1'b0, 8'h00);
        base = rx_q.size();
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, exp_sim[k]);
        guard = 0;
        while (cyc + 1 < next_pop && guard < 100) begin
            tick(1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("t7_level_full", 32'(fifo_level), 32'd4);
        tick(1'b0, 1'b1, 8'hEE);
        check("t7_level_after", 32'(fifo_level), 32'd3);
        check("t7_ovf",         32'(overflow),   32'd1);
        drain("t7", 600);
        check("t7_count", 32'(rx_q.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) check("t7_byte", 32'(rx_q[base + k]), 32'(exp_sim[k]));

        // Every completed frame decoded matches the model's pop order
        check("all_count", 32'(rx_q.size()), 32'(m_popped.size()));
        for (int k = 0; k < rx_q.size() && k < m_popped.size(); k++)
            check("all_byte", 32'(rx_q[k]), 32'(m_popped[k]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
